// File: rtl/sensor_conditioner.sv
// sensor_conditioner
//   Conditions the two raw sensor inputs that feed the occupancy/alarm FSM.
//   Each channel runs through a 2-FF synchroniser and a counter-based
//   debouncer. A level change is accepted only after DEBOUNCE_CYCLES
//   consecutive synchronised samples that differ from the current level.
//   A change that reverts before then is dropped and counted as a glitch.
//
// Ports
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous reset, active-high
//   sensor1_raw  in   1         raw asynchronous sensor 1
//   sensor2_raw  in   1         raw asynchronous sensor 2
//   sensor1_o    out  1         debounced level, sensor 1
//   sensor2_o    out  1         debounced level, sensor 2
//   s1_rise      out  1         one-cycle pulse when sensor1_o goes 0->1
//   s1_fall      out  1         one-cycle pulse when sensor1_o goes 1->0
//   s2_rise      out  1         one-cycle pulse when sensor2_o goes 0->1
//   s2_fall      out  1         one-cycle pulse when sensor2_o goes 1->0
//   both_active  out  1         registered sensor1_o & sensor2_o
//   glitch_cnt   out  GLITCH_W  saturating count of aborted transitions
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 20,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sensor1_raw,
  input  logic                sensor2_raw,
  output logic                sensor1_o,
  output logic                sensor2_o,
  output logic                s1_rise,
  output logic                s1_fall,
  output logic                s2_rise,
  output logic                s2_fall,
  output logic                both_active,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam int                  GW1        = GLITCH_W + 1;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  typedef struct packed {
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             level;
  } db_reg_t;

  typedef struct packed {
    db_reg_t r;
    logic    rise;
    logic    fall;
    logic    abort;
  } db_next_t;

  // Next-state function shared by both channels, so the two debouncers
  // cannot drift apart in behaviour.
  function automatic db_next_t db_step(input db_reg_t cur, input logic sample);
    db_next_t n;
    n       = '0;
    n.r     = cur;
    unique case (cur.state)
      STABLE: begin
        if (sample != cur.level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            n.r.level = ~cur.level;
            n.rise    = ~cur.level;
            n.fall    = cur.level;
          end else begin
            // The first differing sample already counts as one.
            n.r.state = PENDING;
            n.r.cnt   = CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (sample == cur.level) begin
          n.r.state = STABLE;
          n.r.cnt   = '0;
          n.abort   = 1'b1;
        end else if (cur.cnt == CNT_LAST) begin
          n.r.state = STABLE;
          n.r.cnt   = '0;
          n.r.level = ~cur.level;
          n.rise    = ~cur.level;
          n.fall    = cur.level;
        end else begin
          n.r.cnt   = cur.cnt + CNT_W'(1);
        end
      end
      default: n.r = '0;
    endcase
    return n;
  endfunction

  logic [1:0]          ff1;
  logic [1:0]          sync_q;
  db_reg_t             ch1_q, ch2_q;
  db_next_t            nxt1, nxt2;
  logic                s1_rise_q, s1_fall_q, s2_rise_q, s2_fall_q;
  logic                both_q;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W:0]   glitch_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1    <= '0;
      sync_q <= '0;
    end else begin
      ff1    <= {sensor2_raw, sensor1_raw};
      sync_q <= ff1;
    end
  end

  always_comb begin
    nxt1       = db_step(ch1_q, sync_q[0]);
    nxt2       = db_step(ch2_q, sync_q[1]);
    // One spare bit catches overflow so the count saturates instead of wrapping.
    glitch_sum = {1'b0, glitch_q} + GW1'(nxt1.abort) + GW1'(nxt2.abort);
    glitch_d   = glitch_sum[GLITCH_W] ? GLITCH_MAX : glitch_sum[GLITCH_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch1_q     <= '0;
      ch2_q     <= '0;
      s1_rise_q <= 1'b0;
      s1_fall_q <= 1'b0;
      s2_rise_q <= 1'b0;
      s2_fall_q <= 1'b0;
      both_q    <= 1'b0;
      glitch_q  <= '0;
    end else begin
      ch1_q     <= nxt1.r;
      ch2_q     <= nxt2.r;
      s1_rise_q <= nxt1.rise;
      s1_fall_q <= nxt1.fall;
      s2_rise_q <= nxt2.rise;
      s2_fall_q <= nxt2.fall;
      // Built from next-cycle levels so it moves on the same edge as the later level.
      both_q    <= nxt1.r.level & nxt2.r.level;
      glitch_q  <= glitch_d;
    end
  end

  assign sensor1_o   = ch1_q.level;
  assign sensor2_o   = ch2_q.level;
  assign s1_rise     = s1_rise_q;
  assign s1_fall     = s1_fall_q;
  assign s2_rise     = s2_rise_q;
  assign s2_fall     = s2_fall_q;
  assign both_active = both_q;
  assign glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner
//   Scoreboard bench for sensor_conditioner (DEBOUNCE_CYCLES=4, GLITCH_W=4).
//   The stimulus task advances a reference model one clock and queues the
//   expected output vector. A monitor pops that vector after every rising
//   edge and compares it with the DUT. Directed phases add spot checks
//   against fixed constants.
module tb_sensor_conditioner;

  localparam int D    = 4;
  localparam int GW   = 4;
  localparam int GMAX = (1 << GW) - 1;

  typedef logic [10:0] obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sensor1_raw, sensor2_raw;
  logic          sensor1_o, sensor2_o;
  logic          s1_rise, s1_fall, s2_rise, s2_fall;
  logic          both_active;
  logic [GW-1:0] glitch_cnt;
  obs_t          obs;

  always #5 clk = ~clk;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(20),
    .GLITCH_W(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sensor1_raw(sensor1_raw),
    .sensor2_raw(sensor2_raw),
    .sensor1_o(sensor1_o),
    .sensor2_o(sensor2_o),
    .s1_rise(s1_rise),
    .s1_fall(s1_fall),
    .s2_rise(s2_rise),
    .s2_fall(s2_fall),
    .both_active(both_active),
    .glitch_cnt(glitch_cnt)
  );

  assign obs = {sensor1_o, sensor2_o, s1_rise, s1_fall, s2_rise, s2_fall,
                both_active, glitch_cnt};

  int    checks = 0;
  int    passes = 0;
  string phase  = "reset";
  obs_t  exp_q[$];

  // Reference model: raw samples reach the debouncer two edges later.
  // A level flips after D consecutive differing samples. A differing run
  // that ends early counts as one glitch.
  logic m_p0[2];
  logic m_p1[2];
  logic m_lvl[2];
  int   m_run[2];
  int   m_glitch;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_p0[c] = 1'b0; m_p1[c] = 1'b0; m_lvl[c] = 1'b0; m_run[c] = 0;
    end
    m_glitch = 0;
  endtask

  task automatic step(input logic a, input logic b, input logic rv);
    logic raw[2];
    logic rise[2];
    logic fall[2];
    int   ev;
    obs_t e;
    @(negedge clk);
    sensor1_raw = a;
    sensor2_raw = b;
    rst         = rv;
    raw[0] = a; raw[1] = b;
    rise[0] = 1'b0; rise[1] = 1'b0; fall[0] = 1'b0; fall[1] = 1'b0;
    if (rv) begin
      model_clear();
    end else begin
      ev = 0;
      for (int c = 0; c < 2; c++) begin
        if (m_p1[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = ~m_lvl[c];
            rise[c]  = m_lvl[c];
            fall[c]  = ~m_lvl[c];
            m_run[c] = 0;
          end
        end else begin
          if (m_run[c] > 0) ev++;
          m_run[c] = 0;
        end
        m_p1[c] = m_p0[c];
        m_p0[c] = raw[c];
      end
      m_glitch = (m_glitch + ev > GMAX) ? GMAX : m_glitch + ev;
    end
    e = {m_lvl[0], m_lvl[1], rise[0], fall[0], rise[1], fall[1],
         m_lvl[0] & m_lvl[1], GW'(m_glitch)};
    exp_q.push_back(e);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({phase, " outputs"}, 32'(obs), 32'(e));
      end
    end
  end

  initial begin : driver
    logic v1, v2;
    int   rem1, rem2;
    rst = 1'b1; sensor1_raw = 1'b0; sensor2_raw = 1'b0;
    model_clear();

    // Reset with raw high, then release and hold.
    phase = "t1_reset";
    repeat (3) step(1'b1, 1'b1, 1'b1);
    peek();
    check("t1 reset outputs", 32'(obs), 32'(0));
    repeat (4) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    peek();
    check("t1 level before accept", {sensor1_o, sensor2_o}, 2'b00);
    step(1'b1, 1'b1, 1'b0);
    peek();
    check("t1 accept levels+rise+both", {sensor1_o, sensor2_o, s1_rise, s2_rise, both_active}, 5'b11111);
    step(1'b1, 1'b1, 1'b0);
    peek();
    check("t1 rise cleared", {s1_rise, s2_rise, sensor1_o, sensor2_o}, 4'b0011);

    // Bounce shorter than the debounce window.
    phase = "t2_bounce";
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    peek();
    check("t2 level stays low", sensor1_o, 1'b0);
    check("t2 glitch count", glitch_cnt, 4'd1);

    // Clean fall on channel 1 with channel 2 held high.
    phase = "t3_fall";
    repeat (8) step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0);
    peek();
    check("t3 level before fall", {sensor1_o, both_active}, 2'b11);
    step(1'b0, 1'b1, 1'b0);
    peek();
    check("t3 fall edge", {sensor1_o, s1_fall, s1_rise, both_active}, 4'b0100);
    step(1'b0, 1'b1, 1'b0);
    peek();
    check("t3 fall cleared", s1_fall, 1'b0);

    // Saturation of the glitch counter with simultaneous bounces.
    phase = "t4_saturate";
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0, 1'b0);
    peek();
    check("t4 glitch saturated", glitch_cnt, 4'd15);

    // Reset while a transition is pending.
    phase = "t5_rst_pending";
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    peek();
    check("t5 cleared by reset", {sensor1_o, s1_rise, glitch_cnt}, 6'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    peek();
    check("t5 no early rise", {sensor1_o, glitch_cnt}, 5'd0);
    step(1'b1, 1'b0, 1'b0);
    peek();
    check("t5 rise after full latency", {sensor1_o, s1_rise}, 2'b11);

    // Random run lengths on both channels.
    phase = "t6_random";
    v1 = 1'b1; v2 = 1'b0; rem1 = 0; rem2 = 0;
    repeat (400) begin
      if (rem1 == 0) begin v1 = ~v1; rem1 = $urandom_range(1, 10); end
      if (rem2 == 0) begin v2 = ~v2; rem2 = $urandom_range(1, 10); end
      rem1--; rem2--;
      step(v1, v2, 1'b0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
